fir_mac_ctrl: RTL and testbench

Folded, sequenced 9-tap low-pass FIR controller. It time-shares one multiply-accumulate unit across all taps, so each output sample costs TAPS cycles instead of TAPS multipliers. It also owns the sample circular buffer and a run-time-writable coefficient bank. It sits between the ADC sample stream and downstream processing, and uses valid/ready handshakes on both sides plus a configuration write port.

---
 rtl/fir_mac_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fir_mac_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_ctrl.sv
// fir_mac_ctrl: folded 9-tap FIR controller.
// A single multiply-accumulate unit is stepped across all taps, one tap per
// cycle. The block also owns the sample circular buffer and a coefficient
// bank that can be rewritten at run time while the block is idle.
// Optional feature macro: FIR_MAC_SAT_EN (widened accumulator with a
// saturating output slice). Without it the accumulator wraps.
module fir_mac_ctrl #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 9,
    parameter int ACC_W     = 27,
    parameter int OUT_SHIFT = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              cfg_we,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    output logic              busy
);

    localparam int PTR_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int TOP    = OUT_SHIFT + DATA_W;
`ifdef FIR_MAC_SAT_EN
    localparam int ACC_I  = ACC_W + 2;
`else
    localparam int ACC_I  = ACC_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   newest_q, newest_d;
    logic [PTR_W-1:0]   k_q, k_d;
    logic [ACC_I-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]  smp_q [TAPS];
    logic [DATA_W-1:0]  smp_d [TAPS];
    logic [COEF_W-1:0]  coef_q [TAPS];
    logic [COEF_W-1:0]  coef_d [TAPS];
    logic [PTR_W-1:0]   rd_idx;
    logic [PROD_W-1:0]  prod;

    // Low-pass coefficient set loaded at reset.
    function automatic logic [COEF_W-1:0] default_coef(input int idx);
        case (idx)
            0, 8:    default_coef = COEF_W'(7);
            1, 7:    default_coef = COEF_W'(5);
            2, 6:    default_coef = COEF_W'(51);
            3, 5:    default_coef = COEF_W'(135);
            4:       default_coef = COEF_W'(179);
            default: default_coef = '0;
        endcase
    endfunction

    // Tap read index walks backwards in time from the newest sample.
    always_comb begin
        rd_idx = (newest_q >= k_q) ? (newest_q - k_q)
                                   : PTR_W'(int'(newest_q) + TAPS - int'(k_q));
        prod   = PROD_W'(smp_q[rd_idx]) * PROD_W'(coef_q[k_q]);
    end

    // Next-state, handshake decode and datapath updates.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        newest_d  = newest_q;
        k_d       = k_q;
        acc_d     = acc_q;
        smp_d     = smp_q;
        coef_d    = coef_q;
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
                // Out-of-range tap indices are silently dropped.
                if (cfg_we && (int'(cfg_addr) < TAPS)) begin
                    coef_d[cfg_addr] = cfg_data;
                end
                if (in_valid) begin
                    smp_d[wr_ptr_q] = in_data;
                    newest_d        = wr_ptr_q;
                    wr_ptr_d        = (int'(wr_ptr_q) == TAPS - 1) ? '0 : wr_ptr_q + 1'b1;
                    acc_d           = '0;
                    k_d             = '0;
                    state_d         = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + ACC_I'(prod);
                if (int'(k_q) == TAPS - 1) begin
                    state_d = S_OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = ~in_ready;

    // Output slice of the accumulator, held while the FSM waits in OUT.
`ifdef FIR_MAC_SAT_EN
    always_comb begin
        out_data = (|acc_q[ACC_I-1:TOP]) ? '1 : acc_q[TOP-1:OUT_SHIFT];
    end
`else
    always_comb begin
        out_data = acc_q[TOP-1:OUT_SHIFT];
    end
`endif

    // Control and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            newest_q <= '0;
            k_q      <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            newest_q <= newest_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
        end
    end

    // Sample buffer and coefficient bank.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these small arrays are flops with defined reset contents, so they are reset like any other state.
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                smp_q[i]  <= '0;
                coef_q[i] <= default_coef(i);
            end
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                smp_q[i]  <= smp_d[i];
                coef_q[i] <= coef_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Directed testbench for fir_mac_ctrl: impulse, step, backpressure,
// coefficient writes, overflow and mid-computation reset.
module tb_fir_mac_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        cfg_we;
    logic        cfg_ready;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    fir_mac_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offer one sample and wait (bounded) for it to be accepted.
    task automatic send_sample(input logic [15:0] d);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: in_ready never rose for sample %0d", d);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, capture out_data, then complete the handshake.
    // lat counts clock edges from the acceptance edge to the handshake edge.
    task automatic recv_output(output logic [15:0] d, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        if (!out_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL recv_timeout: out_valid never rose");
        end
        d = out_data;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] v);
        int t;
        t = 0;
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = v;
        while (!cfg_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cfg_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL cfg_timeout: cfg_ready never rose");
        end
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || busy !== 1'b0 ||
            in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_outputs: got v=%b d=%0d busy=%b ir=%b cr=%b expected 0 0 0 1 1",
                     out_valid, out_data, busy, in_ready, cfg_ready);
        end
    endtask

    task automatic test_impulse();
        logic [15:0] exp_tab [10] = '{16'd7, 16'd5, 16'd51, 16'd135, 16'd179,
                                      16'd135, 16'd51, 16'd5, 16'd7, 16'd0};
        logic [15:0] d;
        int lat;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_sample((i == 0) ? 16'd2048 : 16'd0);
            recv_output(d, lat);
            n_checks++;
            if (d !== exp_tab[i]) begin
                n_errors++;
                $display("FAIL impulse_out[%0d]: got %0d expected %0d", i, d, exp_tab[i]);
            end
            n_checks++;
            if (lat !== 10) begin
                n_errors++;
                $display("FAIL impulse_latency[%0d]: got %0d expected 10", i, lat);
            end
        end
    endtask

    task automatic test_step();
        logic [15:0] exp_tab [10] = '{16'd3, 16'd5, 16'd30, 16'd96, 16'd184,
                                      16'd250, 16'd274, 16'd277, 16'd280, 16'd280};
        logic [15:0] d;
        int lat;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_sample(16'd1000);
            recv_output(d, lat);
            n_checks++;
            if (d !== exp_tab[i]) begin
                n_errors++;
                $display("FAIL step_out[%0d]: got %0d expected %0d", i, d, exp_tab[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int t;
        do_reset();
        send_sample(16'd2048);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 100);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 16'd7 || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL backpressure_hold[%0d]: got v=%b d=%0d ir=%b busy=%b expected 1 7 0 1",
                         i, out_valid, out_data, in_ready, busy);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL backpressure_release: got ir=%b v=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_cfg_idle_with_sample();
        logic [15:0] exp_tab [9] = '{16'd7, 16'd5, 16'd51, 16'd135, 16'd0,
                                     16'd135, 16'd51, 16'd5, 16'd7};
        logic [15:0] d;
        int lat;
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'd2048;
        cfg_we   = 1'b1;
        cfg_addr = 4'd4;
        cfg_data = 8'd0;
        n_checks++;
        if (in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL cfg_idle_ready: got ir=%b cr=%b expected 1 1", in_ready, cfg_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i != 0) send_sample(16'd0);
            recv_output(d, lat);
            n_checks++;
            if (d !== exp_tab[i]) begin
                n_errors++;
                $display("FAIL cfg_idle_out[%0d]: got %0d expected %0d", i, d, exp_tab[i]);
            end
        end
    endtask

    task automatic test_cfg_dropped();
        logic [15:0] exp_tab [5] = '{16'd7, 16'd5, 16'd51, 16'd135, 16'd179};
        logic [15:0] d;
        int lat;
        do_reset();
        send_sample(16'd2048);
        // Write attempt while the MAC is running must be dropped.
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = 4'd1;
        cfg_data = 8'd99;
        n_checks++;
        if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL cfg_mac_ready: got cr=%b busy=%b expected 0 1", cfg_ready, busy);
        end
        repeat (3) @(negedge clk);
        cfg_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) cfg_write(4'd12, 8'd0);
            if (i != 0) send_sample(16'd0);
            recv_output(d, lat);
            n_checks++;
            if (d !== exp_tab[i]) begin
                n_errors++;
                $display("FAIL cfg_dropped_out[%0d]: got %0d expected %0d", i, d, exp_tab[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        logic [15:0] exp_last;
        int lat;
`ifdef FIR_MAC_SAT_EN
        exp_last = 16'hFFFF;
`else
        exp_last = 16'd7902;
`endif
        do_reset();
        for (int i = 0; i < 9; i++) cfg_write(4'(i), 8'd255);
        for (int i = 0; i < 9; i++) begin
            send_sample(16'd65535);
            recv_output(d, lat);
            if (i == 0) begin
                n_checks++;
                if (d !== 16'd8159) begin
                    n_errors++;
                    $display("FAIL overflow_first: got %0d expected 8159", d);
                end
            end
            if (i == 1) begin
                n_checks++;
                if (d !== 16'd16319) begin
                    n_errors++;
                    $display("FAIL overflow_second: got %0d expected 16319", d);
                end
            end
            if (i == 8) begin
                n_checks++;
                if (d !== exp_last) begin
                    n_errors++;
                    $display("FAIL overflow_ninth: got %0d expected %0d", d, exp_last);
                end
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        logic [15:0] exp_tab [3] = '{16'd7, 16'd5, 16'd51};
        logic [15:0] d;
        int lat;
        logic seen_valid;
        do_reset();
        cfg_write(4'd0, 8'd200);
        send_sample(16'd2048);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_async: got v=%b ir=%b busy=%b expected 0 1 0",
                     out_valid, in_ready, busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_no_valid: got out_valid=1 expected 0");
        end
        for (int i = 0; i < 3; i++) begin
            send_sample((i == 0) ? 16'd2048 : 16'd0);
            recv_output(d, lat);
            n_checks++;
            if (d !== exp_tab[i]) begin
                n_errors++;
                $display("FAIL midreset_impulse[%0d]: got %0d expected %0d", i, d, exp_tab[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_backpressure();
        test_cfg_idle_with_sample();
        test_cfg_dropped();
        test_overflow();
        test_reset_mid_mac();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
